scan_response_reader: RTL
=========================

SCAN_RESPONSE_READER -- requirements
Module: scan_response_reader

Interface
REQ-001 SHALL have parameter LW, default 8, which sets the width of the length, index and error-count fields.
REQ-002 SHALL have port C, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port R, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port START, input, 1 bit: request to unload and check one chain.
REQ-005 SHALL have port LEN, input, LW bits: chain length in bits, sampled with START.
REQ-006 SHALL have port SO, input, 1 bit: serial scan-out bit from the chain.
REQ-007 SHALL have port EXP, input, 1 bit: expected fault-free value of SO.
REQ-008 SHALL have port MASK, input, 1 bit: when 1, excludes the current bit from comparison.
REQ-009 SHALL have port SE, output, 1 bit: scan-enable that shifts the chain by one bit per cycle.
REQ-010 SHALL have port BUSY, output, 1 bit: high while an unload is in progress.
REQ-011 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port FAIL, output, 1 bit: high when at least one unmasked mismatch occurred.
REQ-013 SHALL have port ERR_CNT, output, LW bits: count of unmasked mismatches.
REQ-014 SHALL have port FIRST_IDX, output, LW bits: bit index of the first mismatch.

Function
REQ-015 SHALL implement a state machine with states IDLE, SHIFT and FIN.
REQ-016 SHALL, in IDLE with START=1 and LEN!=0, latch LEN, clear FAIL, ERR_CNT, FIRST_IDX and the bit index, and enter SHIFT.
REQ-017 SHALL, in IDLE with START=1 and LEN==0, enter FIN directly, clear the results, and assert SE for no cycles.
REQ-018 SHALL drive SE=1 and BUSY=1 combinationally throughout SHIFT, and SE=0 in every other state.
REQ-019 SHALL, on each SHIFT cycle, compare SO against EXP at bit index i; the first cycle after START is i=0.
REQ-020 SHALL count a mismatch only when SO!=EXP and MASK=0.
REQ-021 SHALL, on the first counted mismatch, set FAIL=1 and FIRST_IDX=i; later mismatches SHALL NOT change FIRST_IDX.
REQ-022 SHALL increment ERR_CNT on each counted mismatch, saturating at 2^LW-1 with no wrap.
REQ-023 SHALL leave SHIFT for FIN after exactly LEN SHIFT cycles, i.e. after the cycle with i=LEN-1.
REQ-024 SHALL, in FIN, assert DONE for one cycle with BUSY=1, then return to IDLE.
REQ-025 SHALL ignore START while in SHIFT or FIN.
REQ-026 SHALL hold FAIL, ERR_CNT and FIRST_IDX stable in IDLE until the next accepted START.
REQ-027 SHALL drive FIRST_IDX=0 whenever FAIL=0.

Reset
REQ-028 SHALL, while R=1, force state IDLE and SE=0, BUSY=0, DONE=0, FAIL=0, ERR_CNT=0, FIRST_IDX=0 and the bit index to 0, independent of C.
REQ-029 SHALL, when R asserts mid-SHIFT, abandon the unload without producing a DONE pulse.
REQ-030 SHALL accept a START on the first rising edge of C after R deasserts.

Configuration
REQ-031 SHALL, with macro SCAN_RESP_MISR_EN defined, add output SIG (16 bits): a MISR using polynomial x^16+x^12+x^5+1, clocked with SO on each SHIFT cycle regardless of MASK.
REQ-032 SHALL, with SCAN_RESP_MISR_EN defined, clear SIG on reset and on an accepted START, and hold SIG stable outside SHIFT.
REQ-033 SHALL, without SCAN_RESP_MISR_EN, omit the SIG port and the MISR logic entirely, leaving all other behaviour identical.

Verification
REQ-034 SHALL cover: LEN=8, SO=EXP every cycle -> exactly 8 SE cycles, then DONE pulse, FAIL=0, ERR_CNT=0.
REQ-035 SHALL cover: LEN=8, mismatches at i=2 and i=5 -> FAIL=1, ERR_CNT=2, FIRST_IDX=2.
REQ-036 SHALL cover: LEN=4, mismatch at i=1 with MASK=1 and at i=3 with MASK=0 -> ERR_CNT=1, FIRST_IDX=3.
REQ-037 SHALL cover: LEN=0 with START -> no SE cycle, DONE 2 cycles after START, FAIL=0.
REQ-038 SHALL cover: LW=8, LEN=255, all bits mismatching, followed by a second START with LEN=255, all mismatching -> ERR_CNT=255 (saturated) and FIRST_IDX=0 at the end of each run.
REQ-039 SHALL cover: R pulsed at i=3 of LEN=8 -> outputs return to 0 immediately, no DONE pulse, and a fresh START then completes normally.

Source files
------------

// File: rtl/scan_response_reader.sv
// rtl/scan_response_reader.sv - unloads one scan chain and checks it bit by bit against expected data
//
// Purpose: on an accepted START, shift the chain for LEN cycles, compare SO
// with EXP on every unmasked bit, and report the pass/fail status, the
// mismatch count and the index of the first mismatch.
//
// Optional feature macro: SCAN_RESP_MISR_EN adds the 16-bit SIG signature output.
//
// Ports:
//   C          in   clock, rising edge
//   R          in   asynchronous active-high reset
//   START      in   begin unload of one chain (accepted only in IDLE)
//   LEN        in   chain length in bits, sampled with START
//   SO         in   serial scan-out bit from the chain
//   EXP        in   expected fault-free value of SO
//   MASK       in   1 = exclude the current bit from comparison
//   SE         out  scan enable, high on every SHIFT cycle
//   BUSY       out  unload in progress (SHIFT or FIN)
//   DONE       out  one-cycle completion pulse
//   FAIL       out  at least one unmasked mismatch seen
//   ERR_CNT    out  saturating count of unmasked mismatches
//   FIRST_IDX  out  bit index of the first unmasked mismatch (0 when FAIL=0)
//   SIG        out  MISR signature of SO (only with SCAN_RESP_MISR_EN)
module scan_response_reader #(
  parameter int LW = 8
) (
  input  logic          C,
  input  logic          R,
  input  logic          START,
  input  logic [LW-1:0] LEN,
  input  logic          SO,
  input  logic          EXP,
  input  logic          MASK,
  output logic          SE,
  output logic          BUSY,
  output logic          DONE,
  output logic          FAIL,
  output logic [LW-1:0] ERR_CNT,
  output logic [LW-1:0] FIRST_IDX
`ifdef SCAN_RESP_MISR_EN
  ,
  output logic [15:0]   SIG
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  // x^16 + x^12 + x^5 + 1, the x^16 term being the feedback tap itself
  localparam logic [15:0] MISR_POLY = 16'h1021;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] len_q,   len_d;
  logic [LW-1:0] idx_q,   idx_d;
  logic          fail_q,  fail_d;
  logic [LW-1:0] cnt_q,   cnt_d;
  logic [LW-1:0] first_q, first_d;
`ifdef SCAN_RESP_MISR_EN
  logic [15:0]   sig_q,   sig_d;
`endif

  logic hit;
  logic last_bit;

  // Only counted mismatches matter; masked bits still shift but never score.
  assign hit      = (SO ^ EXP) & ~MASK;
  assign last_bit = (idx_q == (len_q - LW'(1)));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    first_d = first_q;
`ifdef SCAN_RESP_MISR_EN
    sig_d   = sig_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          len_d   = LEN;
          idx_d   = '0;
          fail_d  = 1'b0;
          cnt_d   = '0;
          first_d = '0;
`ifdef SCAN_RESP_MISR_EN
          sig_d   = '0;
`endif
          // A zero-length chain skips shifting entirely and just reports.
          state_d = (LEN == '0) ? ST_FIN : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (hit) begin
          if (!fail_q) begin
            fail_d  = 1'b1;
            first_d = idx_q;
          end
          if (cnt_q != {LW{1'b1}}) begin
            cnt_d = cnt_q + LW'(1);
          end
        end
`ifdef SCAN_RESP_MISR_EN
        // Signature covers every shifted bit, masked or not.
        sig_d = {sig_q[14:0], 1'b0} ^ ({16{sig_q[15]}} & MISR_POLY) ^ {15'd0, SO};
`endif
        idx_d = idx_q + LW'(1);
        if (last_bit) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
`ifdef SCAN_RESP_MISR_EN
      sig_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
`ifdef SCAN_RESP_MISR_EN
      sig_q   <= sig_d;
`endif
    end
  end

  assign SE        = (state_q == ST_SHIFT);
  assign BUSY      = (state_q == ST_SHIFT) || (state_q == ST_FIN);
  assign DONE      = (state_q == ST_FIN);
  assign FAIL      = fail_q;
  assign ERR_CNT   = cnt_q;
  assign FIRST_IDX = first_q;
`ifdef SCAN_RESP_MISR_EN
  assign SIG       = sig_q;
`endif

endmodule
